tx_fifo_wr_arbiter: RTL
=======================

# tx_fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the UART TX FIFO between several on-chip byte producers. It sits upstream of the TX FIFO, which feeds the TX state machine. Each grant is locked for a whole message, ending on the producer's `last` flag or a burst limit, so bytes from different producers never interleave inside a message. FIFO full backpressure is forwarded to the granted producer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 8: maximum bytes per grant, 1..255. Only used with `ARB_BURST_LIMIT_EN`.

- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Cfg_ctrl_arb_en`  in  1  enables issuing new grants.
- `Req_valid`  in  NUM_REQ  per-requester byte valid.
- `Req_last`  in  NUM_REQ  the current byte ends the message.
- `Req_data`  in  8*NUM_REQ  bytes; requester i uses bits [8i+7:8i].
- `Arb_ready`  out  NUM_REQ  byte accepted this cycle when ANDed with `Req_valid`.
- `Arb_grant`  out  NUM_REQ  registered one-hot grant; all zero when idle.
- `FIFO_ctrl_full`  in  1  TX FIFO full.
- `Arb_FIFO_w_en`  out  1  FIFO write strobe.
- `Arb_FIFO_w_data`  out  8  FIFO write data.
- `Arb_busy`  out  1  high while in LOCKED.

## Operation
- **States:** IDLE, LOCKED. The state, `Arb_grant`, the round-robin pointer `ptr` (clog2(NUM_REQ) bits) and the burst counter `bcnt` (clog2(MAX_BURST+1) bits) are all registers.
- **IDLE:**
  - If `Cfg_ctrl_arb_en` is high and any `Req_valid` is high, grant the first valid index found searching `ptr`, `ptr`+1, … with wrap modulo NUM_REQ.
  - The grant is loaded at the next edge, with a move to LOCKED and `bcnt`=0.
  - Otherwise stay in IDLE.
- **LOCKED, granted index g:**
  - `Arb_ready[g]` = !`FIFO_ctrl_full`. All other `Arb_ready` bits are 0.
  - Accept = `Req_valid[g]` & !`FIFO_ctrl_full`.
  - `Arb_FIFO_w_en` = accept, combinational. `Arb_FIFO_w_data` = `Req_data[g]`; it is 0 when `Arb_FIFO_w_en` is low.
  - Each accept increments `bcnt`.
- **Release:** happens on an accepted byte with `Req_last[g]`, or on the accept that brings `bcnt` to MAX_BURST (`ARB_BURST_LIMIT_EN` only). At the next edge:
  - state goes to IDLE;
  - `Arb_grant` goes to 0;
  - `ptr` becomes (g+1) mod NUM_REQ.
- **Boundary conditions:**
  - When `Req_valid[g]` drops while LOCKED, the grant is held indefinitely and no timeout applies.
  - When `FIFO_ctrl_full` is high, nothing is written and `bcnt` holds. Data is unchanged from the requester's side.
  - When `Cfg_ctrl_arb_en` goes low while LOCKED, the current message finishes normally. Only new grants are blocked.
  - `Req_last` on a non-accepted cycle is ignored.
  - Reset mid-message: the grant is dropped immediately and the partial message stays in the FIFO. Recovery is the producer's responsibility.

## Timing
- **Reset values:**
  - state=IDLE, `ptr`=0, `bcnt`=0;
  - `Arb_grant`=0, `Arb_ready`=0, `Arb_busy`=0;
  - `Arb_FIFO_w_en`=0, `Arb_FIFO_w_data`=0.
- **Grant latency:** `Req_valid` sampled in IDLE at edge N gives `Arb_grant` at N+1. The first write happens in cycle N+1 if the FIFO is not full.
- **Throughput:** 1 byte/cycle while locked. A release always costs exactly one IDLE cycle, a re-arbitration bubble, even if other requests are pending.
- `Arb_ready` and `Arb_FIFO_w_en` are combinational from `FIFO_ctrl_full`, `Req_valid` and the registered grant. They have no path from `Req_data`.

## Configuration
- `ARB_BURST_LIMIT_EN` defined: the grant also releases after MAX_BURST accepted bytes, even without `Req_last`. The requester re-arbitrates for the remainder, and `Req_last` still releases early.
- `ARB_BURST_LIMIT_EN` undefined: `bcnt` is still maintained, but the grant releases only on an accepted `Req_last`. MAX_BURST is unused.

## Test plan
All scenarios use NUM_REQ=4, MAX_BURST=8.
1. **Reset and single producer:** reset, then requester 2 sends 3 bytes 0x11,0x22,0x33 with last on 0x33 → grant 4'b0100 one cycle after valid; 3 consecutive `w_en` pulses with the correct data; IDLE after 0x33; `ptr`=3.
2. **Round robin:** all 4 request continuously, 1-byte messages → grant order 0,1,2,3,0. Each grant is separated by one idle cycle.
3. **Backpressure:** `FIFO_ctrl_full` high for 5 cycles mid-message → `Arb_ready` and `w_en` are 0 for those cycles, no byte is lost or duplicated, and `bcnt` holds.
4. **Burst limit, `ARB_BURST_LIMIT_EN` defined:** requester 1 sends 12 bytes with no last while requester 3 is pending → release after byte 8, requester 3 is served, then requester 1 resumes with byte 9.
5. **Burst limit, `ARB_BURST_LIMIT_EN` undefined:** same stimulus as scenario 4 → all 12 bytes are contiguous before requester 3 is served.
6. **Disable and reset:** `Cfg_ctrl_arb_en` dropped mid-message → the message completes and no new grant is issued. Separately, `rst` asserted mid-message → all outputs are 0 immediately.

Source files
------------

// File: rtl/tx_fifo_wr_arbiter.sv
// Round-robin, message-locked arbiter for the UART TX FIFO write port.
// Optional burst limit enabled by defining ARB_BURST_LIMIT_EN.
module tx_fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Cfg_ctrl_arb_en,
    input  logic [NUM_REQ-1:0]   Req_valid,
    input  logic [NUM_REQ-1:0]   Req_last,
    input  logic [8*NUM_REQ-1:0] Req_data,
    output logic [NUM_REQ-1:0]   Arb_ready,
    output logic [NUM_REQ-1:0]   Arb_grant,
    input  logic                 FIFO_ctrl_full,
    output logic                 Arb_FIFO_w_en,
    output logic [7:0]           Arb_FIFO_w_data,
    output logic                 Arb_busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [PTR_W-1:0]      r_gidx;
    logic [PTR_W-1:0]      r_ptr;
    logic [BCNT_W-1:0]     r_bcnt;

    logic [2*NUM_REQ-1:0]  w_dbl;
    logic [PTR_W:0]        w_sum;
    logic [PTR_W-1:0]      w_pick;
    logic [PTR_W-1:0]      w_gnext;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_burst_hit;
    logic                  w_release;

    assign w_dbl    = {Req_valid, Req_valid};
    assign w_load   = (r_state == IDLE) && Cfg_ctrl_arb_en && (|Req_valid);
    assign w_accept = (r_state == LOCKED) && Req_valid[r_gidx] && !FIFO_ctrl_full;
    assign w_gnext  = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);

`ifdef ARB_BURST_LIMIT_EN
    assign w_burst_hit = (r_bcnt == BCNT_LAST);
`else
    assign w_burst_hit = 1'b0;
`endif

    assign w_release = w_accept && (Req_last[r_gidx] || w_burst_hit);

    // Scan downward so the candidate closest to r_ptr is the last one written.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise a path that skips the assignment infers a latch.
        w_sum  = '0;
        w_pick = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_dbl[w_sum]) begin
                w_pick = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_load)    w_next_state = LOCKED;
            LOCKED:  if (w_release) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
        end else if (w_load) begin
            r_grant         <= '0;
            r_grant[w_pick] <= 1'b1;
            r_gidx          <= w_pick;
            r_bcnt          <= '0;
        end else if (w_accept) begin
            r_bcnt <= r_bcnt + BCNT_W'(1);
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_gnext;
            end
        end
    end

    // Data mux is gated by the strobe so the bus reads zero between writes.
    always_comb begin
        Arb_busy        = (r_state == LOCKED);
        Arb_grant       = r_grant;
        Arb_ready       = (r_state == LOCKED && !FIFO_ctrl_full) ? r_grant : '0;
        Arb_FIFO_w_en   = w_accept;
        Arb_FIFO_w_data = w_accept ? Req_data[{r_gidx, 3'b000} +: 8] : 8'h00;
    end

endmodule
